// File: rtl/stack_mon_pkg.sv
// Shared register map, CTRL bit positions and reset defaults for the stack monitor.
package stack_mon_pkg;

  // Word offsets on the I/O bus (addr = word address bits 3:2)
  localparam logic [1:0] REG_LIMIT = 2'd0;
  localparam logic [1:0] REG_HOT   = 2'd1;
  localparam logic [1:0] REG_HOTPC = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  // CTRL bit indices
  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_OVF = 1;
  localparam int unsigned CTRL_HEN = 2;

  // Reset defaults
  localparam logic [31:0] LIMIT_RST_DEF = 32'h0000_0000;
  localparam logic [31:0] HOT_RST_DEF   = 32'hFFFF_FFFF;

endpackage

// File: rtl/stack_mon.sv
// Stack pointer monitor: overflow trap against a programmable limit, plus
// low-water-mark ("hotspot") tracking, exposed as a 4-register bus slave.
module stack_mon
  import stack_mon_pkg::*;
#(
  parameter logic [31:0] LIMIT_RST = LIMIT_RST_DEF,
  parameter logic [31:0] HOT_RST   = HOT_RST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  input  logic [31:0] spx,
  input  logic [23:0] pcx,
  output logic        ovfl_trig,
  output logic        ovfl
);

  logic [31:0] sp_q;
  logic [23:0] pc_q;
  logic [31:0] limit_q, limit_d;
  logic [31:0] hot_q, hot_d;
  logic [23:0] hotpc_q, hotpc_d;
  logic        en_q, en_d;
  logic        ovf_q, ovf_d;
  logic        hen_q, hen_d;
  logic        trig_q, trig_d;
  logic        ack_q, ack_d;
  logic [31:0] dout_q, dout_d;

  logic        access;
  logic        wr;
  logic        cond;
  logic [31:0] rdata;

  // Next-state for registers, overflow detection, hotspot tracking and bus response
  always_comb begin
    // One access per strobe: the cycle that raises ack is the access cycle
    access  = stb & ~ack_q;
    wr      = access & we;
    cond    = en_q & (sp_q < limit_q);

    limit_d = limit_q;
    hot_d   = hot_q;
    hotpc_d = hotpc_q;
    en_d    = en_q;
    hen_d   = hen_q;
    ovf_d   = ovf_q;

    if (wr && (addr == REG_LIMIT)) begin
      limit_d = data_in;
    end

    // A bus write to HOTSPOT takes precedence over tracking
    if (wr && (addr == REG_HOT)) begin
      hot_d = data_in;
    end else if (hen_q && (sp_q < hot_q)) begin
      hot_d   = sp_q;
      hotpc_d = pc_q;
    end

    if (wr && (addr == REG_CTRL)) begin
      en_d  = data_in[CTRL_EN];
      hen_d = data_in[CTRL_HEN];
    end

    // Set wins over write-1-to-clear
    if (cond) begin
      ovf_d = 1'b1;
    end else if (wr && (addr == REG_CTRL) && data_in[CTRL_OVF]) begin
      ovf_d = 1'b0;
    end

    // Pulse only on the transition into overflow
    trig_d = cond & ~ovf_q;

    ack_d = access;

    unique case (addr)
      REG_LIMIT: rdata = limit_q;
      REG_HOT:   rdata = hot_q;
      REG_HOTPC: rdata = {8'h00, hotpc_q};
      REG_CTRL:  rdata = {29'h0, hen_q, ovf_q, en_q};
      default:   rdata = 32'h0;
    endcase

    dout_d = access ? rdata : 32'h0;
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q    <= 32'h0;
      pc_q    <= 24'h0;
      limit_q <= LIMIT_RST;
      hot_q   <= HOT_RST;
      hotpc_q <= 24'h0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      hen_q   <= 1'b0;
      trig_q  <= 1'b0;
      ack_q   <= 1'b0;
      dout_q  <= 32'h0;
    end else begin
      sp_q    <= spx;
      pc_q    <= pcx;
      limit_q <= limit_d;
      hot_q   <= hot_d;
      hotpc_q <= hotpc_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      hen_q   <= hen_d;
      trig_q  <= trig_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
    end
  end

  assign data_out  = dout_q;
  assign ack       = ack_q;
  assign ovfl_trig = trig_q;
  assign ovfl      = ovf_q;

endmodule

// File: tb/tb_stack_mon.sv
// Self-checking bench for stack_mon: directed scenarios plus randomized
// trials checked against a min/any-below-limit reference model.
module tb_stack_mon;

  logic        clk;
  logic        rst;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic [31:0] spx;
  logic [23:0] pcx;
  logic        ovfl_trig;
  logic        ovfl;

  int checks;
  int errors;
  int trig_cnt;

  // Expected register contents tracked by the bench
  logic [31:0] m_limit;
  logic [31:0] m_hot;
  logic [23:0] m_hotpc;

  stack_mon dut (
    .clk       (clk),
    .rst       (rst),
    .stb       (stb),
    .we        (we),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .ack       (ack),
    .spx       (spx),
    .pcx       (pcx),
    .ovfl_trig (ovfl_trig),
    .ovfl      (ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count trap pulses, sampled away from the active edge
  always @(negedge clk) if (ovfl_trig === 1'b1) trig_cnt = trig_cnt + 1;

  // One bus access: starts at the next negedge, returns at the negedge where ack is seen
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    bit got;
    got = 1'b0;
    r   = 32'h0;
    @(negedge clk);
    stb = 1'b1; we = w; addr = a; data_in = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (got) r = data_out;
    else begin
      checks++; errors++;
      $display("FAIL bus_timeout: addr=%0d no ack within 8 cycles", a);
    end
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    // Build some state: overflow set and a bus access in flight
    spx = 32'h0001_0000;
    bus(1'b1, 2'd0, 32'h0002_0000, r);
    bus(1'b1, 2'd3, 32'h0000_0001, r);
    wait_cycles(3);
    checks++;
    if (ovfl !== 1'b1) begin
      errors++; $display("FAIL pre_reset_ovfl: got %b want 1", ovfl);
    end
    @(negedge clk);
    stb = 1'b1; we = 1'b0; addr = 2'd0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ack, ovfl, ovfl_trig, data_out} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b ovfl=%b trig=%b dout=%h want all 0",
               ack, ovfl, ovfl_trig, data_out);
    end
    @(negedge clk);
    stb = 1'b0;
    rst = 1'b0;
    m_limit = 32'h0; m_hot = 32'hFFFF_FFFF; m_hotpc = 24'h0;
    bus(1'b0, 2'd1, 32'h0, r);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL reset_hotspot: got %h want ffffffff", r);
    end
    bus(1'b0, 2'd3, 32'h0, r);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL reset_ctrl: got %h want 0", r);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int pulses;
    int first;
    spx = 32'h0001_0000;
    bus(1'b1, 2'd0, 32'h0000_8000, r);
    m_limit = 32'h0000_8000;
    bus(1'b1, 2'd3, 32'h0000_0001, r);
    @(negedge clk);
    spx = 32'h0000_7FFC;
    pulses = 0; first = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ovfl_trig === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (pulses != 1 || first != 2) begin
      errors++;
      $display("FAIL ovf_pulse: pulses=%0d at cycle %0d want 1 at cycle 2", pulses, first);
    end
    bus(1'b0, 2'd3, 32'h0, r);
    checks++;
    if (r !== 32'h3) begin
      errors++; $display("FAIL ovf_ctrl: got %h want 3", r);
    end
    pulses = trig_cnt;
    wait_cycles(10);
    checks++;
    if (trig_cnt != pulses) begin
      errors++; $display("FAIL ovf_no_repeat: extra pulses=%0d want 0", trig_cnt - pulses);
    end
  endtask

  task automatic test_w1c_vs_set();
    logic [31:0] r;
    int snap;
    snap = trig_cnt;
    bus(1'b1, 2'd3, 32'h0000_0003, r);
    wait_cycles(2);
    checks++;
    if (ovfl !== 1'b1 || trig_cnt != snap) begin
      errors++;
      $display("FAIL set_wins: ovfl=%b pulses=%0d want ovfl=1 pulses=0", ovfl, trig_cnt - snap);
    end
    bus(1'b0, 2'd3, 32'h0, r);
    checks++;
    if (r !== 32'h3) begin
      errors++; $display("FAIL set_wins_ctrl: got %h want 3", r);
    end
    spx = 32'h0000_9000;
    wait_cycles(2);
    bus(1'b1, 2'd3, 32'h0000_0002, r);
    bus(1'b0, 2'd3, 32'h0, r);
    checks++;
    if (r !== 32'h0 || ovfl !== 1'b0) begin
      errors++; $display("FAIL w1c_clear: ctrl=%h ovfl=%b want 0/0", r, ovfl);
    end
  endtask

  task automatic test_hotspot();
    logic [31:0] r;
    logic [31:0] sps [4];
    logic [23:0] pcs [4];
    sps = '{32'h9000, 32'h8800, 32'h8800, 32'h8C00};
    pcs = '{24'h100, 24'h104, 24'h108, 24'h10C};
    pcx = 24'h100;
    bus(1'b1, 2'd3, 32'h0000_0004, r);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      spx = sps[i]; pcx = pcs[i];
    end
    wait_cycles(3);
    bus(1'b0, 2'd1, 32'h0, r);
    checks++;
    if (r !== 32'h0000_8800) begin
      errors++; $display("FAIL hot_value: got %h want 00008800", r);
    end
    bus(1'b0, 2'd2, 32'h0, r);
    checks++;
    if (r !== 32'h0000_0104) begin
      errors++; $display("FAIL hot_pc: got %h want 00000104", r);
    end
    m_hotpc = 24'h104;
    // Bus write lands in the cycle where sp_r = 0x8000
    @(negedge clk);
    spx = 32'h0000_8000;
    @(negedge clk);
    spx = 32'hFFFF_FFFF;
    stb = 1'b1; we = 1'b1; addr = 2'd1; data_in = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("FAIL hot_wr_ack: got %b want 1", ack);
    end
    stb = 1'b0; we = 1'b0;
    m_hot = 32'hFFFF_FFFF;
    wait_cycles(2);
    bus(1'b0, 2'd1, 32'h0, r);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL hot_write_wins: got %h want ffffffff", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [1:0]  seq [4];
    logic        ack_seen [4];
    logic [31:0] dat [4];
    seq = '{2'd0, 2'd3, 2'd2, 2'd1};
    @(negedge clk);
    stb = 1'b1; we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      ack_seen[i] = ack;
      dat[i]      = data_out;
      addr        = seq[i];
    end
    stb = 1'b0;
    checks++;
    if ({ack_seen[0], ack_seen[1], ack_seen[2], ack_seen[3]} !== 4'b0101) begin
      errors++;
      $display("FAIL b2b_ack: got %b%b%b%b want 0101",
               ack_seen[0], ack_seen[1], ack_seen[2], ack_seen[3]);
    end
    checks++;
    if (dat[1] !== m_limit) begin
      errors++; $display("FAIL b2b_read_limit: got %h want %h", dat[1], m_limit);
    end
    checks++;
    if (dat[3] !== {8'h0, m_hotpc}) begin
      errors++; $display("FAIL b2b_read_hotpc: got %h want %h", dat[3], {8'h0, m_hotpc});
    end
    checks++;
    if (dat[2] !== 32'h0) begin
      errors++; $display("FAIL b2b_idle_data: got %h want 0", dat[2]);
    end
    bus(1'b1, 2'd2, 32'h00DE_ADBE, r);
    bus(1'b0, 2'd2, 32'h0, r);
    checks++;
    if (r !== {8'h0, m_hotpc}) begin
      errors++; $display("FAIL hotpc_ro: got %h want %h", r, {8'h0, m_hotpc});
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] r;
    bus(1'b1, 2'd0, 32'h8000_0000, r);
    m_limit = 32'h8000_0000;
    bus(1'b1, 2'd3, 32'h0000_0001, r);
    @(negedge clk);
    spx = 32'h7FFF_FFFF;
    wait_cycles(3);
    checks++;
    if (ovfl !== 1'b1) begin
      errors++; $display("FAIL unsigned_below: ovfl=%b want 1", ovfl);
    end
    spx = 32'hFFFF_FFF0;
    wait_cycles(2);
    bus(1'b1, 2'd3, 32'h0000_0003, r);
    wait_cycles(3);
    checks++;
    if (ovfl !== 1'b0) begin
      errors++; $display("FAIL unsigned_above: ovfl=%b want 0", ovfl);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] lim;
    logic [31:0] v;
    logic [23:0] p;
    logic [31:0] exp_min;
    logic        exp_ovf;
    int snap;
    for (int t = 0; t < 6; t++) begin
      spx = 32'hFFFF_FFFF;
      wait_cycles(2);
      lim = $urandom;
      bus(1'b1, 2'd0, lim, r);
      bus(1'b1, 2'd1, 32'hFFFF_FFFF, r);
      bus(1'b1, 2'd3, 32'h0000_0007, r);
      snap = trig_cnt;
      exp_min = 32'hFFFF_FFFF;
      exp_ovf = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        v = $urandom;
        if (($urandom & 1) != 0) v = v >> ($urandom_range(0, 8));
        p = 24'($urandom);
        spx = v; pcx = p;
        if (v < exp_min) begin
          exp_min = v;
          m_hotpc = p;
        end
        if (v < lim) exp_ovf = 1'b1;
      end
      @(negedge clk);
      spx = 32'hFFFF_FFFF;
      wait_cycles(3);
      bus(1'b0, 2'd1, 32'h0, r);
      checks++;
      if (r !== exp_min) begin
        errors++; $display("FAIL rand_hot[%0d]: got %h want %h", t, r, exp_min);
      end
      bus(1'b0, 2'd2, 32'h0, r);
      checks++;
      if (r !== {8'h0, m_hotpc}) begin
        errors++; $display("FAIL rand_hotpc[%0d]: got %h want %h", t, r, {8'h0, m_hotpc});
      end
      bus(1'b0, 2'd3, 32'h0, r);
      checks++;
      if (r !== {29'h0, 1'b1, exp_ovf, 1'b1}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got %h want %h", t, r, {29'h0, 1'b1, exp_ovf, 1'b1});
      end
      checks++;
      if ((trig_cnt - snap) != (exp_ovf ? 1 : 0)) begin
        errors++;
        $display("FAIL rand_pulses[%0d]: got %0d want %0d", t, trig_cnt - snap,
                 exp_ovf ? 1 : 0);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; trig_cnt = 0;
    m_limit = 32'h0; m_hot = 32'hFFFF_FFFF; m_hotpc = 24'h0;
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'h0;
    spx = 32'h0001_0000; pcx = 24'h0;
    wait_cycles(2);
    rst = 1'b0;
    test_reset();
    test_overflow();
    test_w1c_vs_set();
    test_hotspot();
    test_back_to_back();
    test_unsigned();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_mon.md
Name: stack_mon

Overview:
- Monitors the CPU's exported stack pointer (spx) and program counter (pcx).
- Raises a sticky overflow flag and a one-cycle trap pulse when the enabled stack pointer drops below a programmable limit.
- Optionally records the lowest stack pointer seen ("hotspot") and the PC at which it occurred.
- Sits downstream of the CPU, on the CPU's sp/pc side-band outputs and on the CPU's word-addressed I/O bus as a 4-register slave; the trap pulse feeds the reset/trap controller.

Parameters:
- LIMIT_RST, 32'h0000_0000, reset value of LIMIT.
- HOT_RST, 32'hFFFF_FFFF, reset and clear value of HOTSPOT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- stb  in  1  bus strobe; already decoded for this device; held by master until ack.
- we  in  1  write enable, qualified by stb.
- addr  in  2  register select (word address bits 3:2).
- data_in  in  32  write data.
- data_out  out  32  read data, valid while ack=1.
- ack  out  1  bus acknowledge.
- spx  in  32  CPU stack pointer value.
- pcx  in  24  CPU program counter value.
- ovfl_trig  out  1  one-cycle overflow trap pulse.
- ovfl  out  1  sticky overflow flag (mirror of CTRL.OVF).

Behaviour:
- One clock. Reset is asynchronous and active-high: port rst, clock port clk. All state is cleared immediately on rst and is independent of clk.
- Reset values:
  - LIMIT = LIMIT_RST, HOTSPOT = HOT_RST, HOT_PC = 0.
  - CTRL = 0, covering EN (bit 0), OVF (bit 1) and HEN (bit 2).
  - sp_r = 0, pc_r = 0.
  - ack = 0, data_out = 0, ovfl_trig = 0, ovfl = 0.
- Sample stage: sp_r <= spx and pc_r <= pcx on every edge. All comparisons use sp_r/pc_r, so latency from an spx change to OVF/HOTSPOT update is 2 edges.
- Overflow detection:
  - cond = EN & (sp_r < LIMIT), unsigned 32-bit compare using the current (pre-write) LIMIT.
  - If cond and OVF=0: OVF <= 1 and ovfl_trig <= 1 for exactly one cycle.
  - If OVF is already 1: no further pulses are produced.
  - OVF clears only by writing CTRL with data_in[1]=1 (write-1-to-clear).
  - If a clear and cond occur in the same cycle, set wins: OVF stays 1 and no new pulse is emitted.
- Hotspot tracking:
  - If HEN & (sp_r < HOTSPOT): HOTSPOT <= sp_r and HOT_PC <= pc_r.
  - A bus write to HOTSPOT in the same cycle wins over tracking.
  - Equality (sp_r == HOTSPOT) does not update.
- Register map (addr):
  - 0 LIMIT: rw.
  - 1 HOTSPOT: rw; a write loads data_in.
  - 2 HOT_PC: ro; zero-extended to 32 bits; writes are ignored.
  - 3 CTRL: bits 0 and 2 are rw, bit 1 is w1c, bits 31:3 read 0.
- Bus handshake:
  - ack <= stb & ~ack, giving one ack per access, 1 cycle after stb.
  - The write takes effect at the same edge that raises ack.
  - data_out is registered at that edge and returns 0 when ack=0.
  - Back-to-back accesses: ack toggles; no access is lost or duplicated.
- Clearing EN does not clear OVF. Setting EN while sp_r is already below LIMIT sets OVF/trig on the next edge.
- rst during a bus access drops ack immediately; the master retries.

Decomposition:
- Shared package stack_mon_pkg:
  - register offsets: REG_LIMIT=0, REG_HOT=1, REG_HOTPC=2, REG_CTRL=3.
  - CTRL bit indices: EN=0, OVF=1, HEN=2.
  - default constants for LIMIT_RST and HOT_RST.
- No sub-module: a single flat block of about 150–200 lines of RTL.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs are 0 immediately. A subsequent read at addr 1 returns FFFF_FFFF; a read at addr 3 returns 0.
- Overflow:
  - Setup: write LIMIT=0x0000_8000, CTRL=1, then drive spx=0x0000_7FFC.
  - Required: ovfl_trig is high for exactly 1 cycle, 2 edges after spx changes.
  - Required: CTRL reads 0x3.
  - Then hold spx low for 10 cycles -> no further pulses.
- W1C versus set: keep spx < LIMIT and write CTRL=0x3 -> OVF remains 1 and no pulse. Then raise spx to 0x9000 and write CTRL=0x2 -> CTRL reads 0x0.
- Hotspot:
  - Setup: CTRL=4; drive spx 0x9000, 0x8800, 0x8800, 0x8C00 with pcx=0x100, 0x104, 0x108, 0x10C.
  - Required: HOTSPOT reads 0x8800 and HOT_PC reads 0x104.
  - Then write HOTSPOT=FFFF_FFFF in the same cycle as sp_r=0x8000 -> reads back FFFF_FFFF.
- Bus: hold stb for 4 cycles with alternating addr -> ack pattern is 0,1,0,1. Each read's data_out matches the register at that access. A write to addr 2 leaves HOT_PC unchanged.
- Unsigned compare: LIMIT=0x8000_0000, spx=0x7FFF_FFFF -> overflow. Then clear OVF and set spx=0xFFFF_FFF0 -> no overflow.
